buffer_reader: RTL

- Read-side flow controller for the circular K-in / J-out parallel buffer.
- Owns the buffer's write and read pointers and its occupancy count, and drives the buffer's write_add, read_add and ld.
- Drains the buffer J words at a time into a registered output stage with a valid/ready handshake to the downstream consumer.
- Sits between the buffer's par_out and the next datapath stage (PE array / accumulator input).

---
 rtl/buffer_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/buffer_reader.sv
// Read-side flow controller for a circular K-in / J-out buffer: owns the write/read
// pointers and occupancy count, and drains J-word groups into a valid/ready output stage.
module buffer_reader #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int J     = 4,
    parameter int BIT   = $clog2(SIZE),
    parameter int CNT   = $clog2(SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_en,
    output logic [BIT-1:0]       write_add,
    output logic                 ld,
    output logic                 space_avail,
    output logic [BIT-1:0]       read_add,
    input  logic [WIDTH*J-1:0]   buf_data,
    output logic [WIDTH*J-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT-1:0]       count,
    output logic                 overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [CNT-1:0] SIZE_C = CNT'(SIZE);
    localparam logic [CNT-1:0] K_C    = CNT'(K);
    localparam logic [CNT-1:0] J_C    = CNT'(J);
    localparam logic [BIT-1:0] K_PTR  = BIT'(K);
    localparam logic [BIT-1:0] J_PTR  = BIT'(J);

    state_t               state_reg;
    logic [BIT-1:0]       write_add_reg;
    logic [BIT-1:0]       read_add_reg;
    logic [CNT-1:0]       count_reg;
    logic [CNT-1:0]       count_next;
    logic [WIDTH*J-1:0]   out_data_reg;
    logic                 overflow_reg;

    logic [CNT-1:0]       free_words;
    logic                 wr_accept;
    logic                 have_group;
    logic                 load;

    assign free_words  = SIZE_C - count_reg;
    assign space_avail = (free_words >= K_C);
    assign wr_accept   = wr_en & space_avail;
    assign have_group  = (count_reg >= J_C);

    // A group is loaded from IDLE, or in VALID when the current group is being taken.
    assign load = have_group & ((state_reg == IDLE) | out_ready);

    always_comb begin
        count_next = count_reg;
        if (wr_accept) begin
            count_next = count_next + K_C;
        end
        if (load) begin
            count_next = count_next - J_C;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            write_add_reg <= '0;
            read_add_reg  <= '0;
            count_reg     <= '0;
            out_data_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            write_add_reg <= '0;
            read_add_reg  <= '0;
            count_reg     <= '0;
            out_data_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (wr_accept) begin
                write_add_reg <= write_add_reg + K_PTR;
            end
            if (wr_en && !space_avail) begin
                overflow_reg <= 1'b1;
            end
            if (load) begin
                out_data_reg <= buf_data;
                read_add_reg <= read_add_reg + J_PTR;
            end
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        state_reg <= VALID;
                    end
                end
                VALID: begin
                    if (out_ready && !have_group) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign write_add = write_add_reg;
    assign read_add  = read_add_reg;
    assign ld        = wr_accept;
    assign out_data  = out_data_reg;
    assign out_valid = (state_reg == VALID);
    assign count     = count_reg;
    assign overflow  = overflow_reg;

    count_in_range: assert property (@(posedge clk) disable iff (!rst) count_reg <= SIZE_C);

endmodule
